// File: rtl/vend_dispenser.sv
// -----------------------------------------------------------------------------
// vend_dispenser
//
// Output-side actuator controller for the vending machine. Turns the vending
// FSM's giveSoda / giveDiet / change requests into timed solenoid pulses:
// one product pulse per vend request and one nickel-ejector pulse per change
// request. Change requests queue in a saturating counter so that none are
// lost while a product is being dispensed.
//
// Parameters:
//   PULSE_W  solenoid on-time in cycles (>= 1)
//   GAP_W    forced off-time after each pulse in cycles (>= 1)
//   CNT_W    width of the pending-nickel counter
//
// Ports:
//   CLK         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   giveSoda    in   soda vend request (level, edge-detected)
//   giveDiet    in   diet vend request (level, edge-detected)
//   change      in   one nickel owed per rising edge
//   soda_sol    out  soda solenoid drive (registered)
//   diet_sol    out  diet solenoid drive (registered)
//   nickel_sol  out  nickel ejector drive (registered)
//   busy        out  not IDLE, or product latched, or nickels pending
//   pending     out  nickels queued but not yet started
//   overflow    out  sticky: a change edge was dropped on a full counter
//   tally       out  products dispensed, 8-bit wrapping counter
//                    (only when VEND_DISP_TALLY_EN is defined)
//
// Build option:
//   VEND_DISP_TALLY_EN  adds the tally output and its counter.
// -----------------------------------------------------------------------------
module vend_dispenser #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int CNT_W   = 3
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             giveSoda,
  input  logic             giveDiet,
  input  logic             change,
  output logic             soda_sol,
  output logic             diet_sol,
  output logic             nickel_sol,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
`ifdef VEND_DISP_TALLY_EN
  ,
  output logic [7:0]       tally
`endif
);

  // The timer only has to hold the longer of the two load values.
  localparam int TMR_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_W - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO   = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PROD_ON = 2'd1,
    ST_NICK_ON = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [TMR_W-1:0]   timer_r;
  logic [TMR_W-1:0]   timer_next_s;

  // Edge detection
  logic               prev_soda_r;
  logic               prev_diet_r;
  logic               prev_change_r;
  logic               soda_edge_s;
  logic               diet_edge_s;
  logic               change_edge_s;

  // Product request latches
  logic               soda_req_r;
  logic               diet_req_r;
  logic               soda_req_next_s;
  logic               diet_req_next_s;

  // Nickel queue
  logic [CNT_W-1:0]   pending_r;
  logic [CNT_W-1:0]   pending_next_s;
  logic               overflow_r;
  logic               overflow_next_s;

  // Solenoid drives
  logic               soda_sol_r;
  logic               diet_sol_r;
  logic               nickel_sol_r;
  logic               soda_sol_next_s;
  logic               diet_sol_next_s;
  logic               nickel_sol_next_s;

  // Pulse-start strobes from the FSM
  logic               start_soda_s;
  logic               start_diet_s;
  logic               start_nick_s;

  // Previous-value registers preset to 1 so a level already high at reset
  // release is not mistaken for a fresh request.
  always_ff @(posedge CLK) begin
    if (rst) begin
      prev_soda_r   <= 1'b1;
      prev_diet_r   <= 1'b1;
      prev_change_r <= 1'b1;
    end else begin
      prev_soda_r   <= giveSoda;
      prev_diet_r   <= giveDiet;
      prev_change_r <= change;
    end
  end

  assign soda_edge_s   = giveSoda & ~prev_soda_r;
  assign diet_edge_s   = giveDiet & ~prev_diet_r;
  assign change_edge_s = change   & ~prev_change_r;

  // Request latch update. A start only happens while the latch is set, so an
  // edge in that same cycle merges into the request being served.
  always_comb begin
    soda_req_next_s = soda_req_r;
    diet_req_next_s = diet_req_r;
    if (start_soda_s) begin
      soda_req_next_s = 1'b0;
    end else begin
      soda_req_next_s = soda_req_r | soda_edge_s;
    end
    if (start_diet_s) begin
      diet_req_next_s = 1'b0;
    end else begin
      diet_req_next_s = diet_req_r | diet_edge_s;
    end
  end

  // Nickel counter: a coincident enqueue and dequeue cancel out, so a full
  // counter can still accept an edge in the cycle a nickel pulse starts.
  always_comb begin
    pending_next_s  = pending_r;
    overflow_next_s = overflow_r;
    if (change_edge_s && !start_nick_s) begin
      if (pending_r == CNT_FULL) begin
        overflow_next_s = 1'b1;
      end else begin
        pending_next_s = pending_r + CNT_ONE;
      end
    end else if (!change_edge_s && start_nick_s) begin
      pending_next_s = pending_r - CNT_ONE;
    end else begin
      pending_next_s = pending_r;
    end
  end

  // Next-state, timer and solenoid logic. Products are always served before
  // nickels, and soda before diet.
  always_comb begin
    state_next_s      = state_r;
    timer_next_s      = timer_r;
    soda_sol_next_s   = soda_sol_r;
    diet_sol_next_s   = diet_sol_r;
    nickel_sol_next_s = nickel_sol_r;
    start_soda_s      = 1'b0;
    start_diet_s      = 1'b0;
    start_nick_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (soda_req_r) begin
          state_next_s      = ST_PROD_ON;
          timer_next_s      = PULSE_LOAD;
          soda_sol_next_s   = 1'b1;
          diet_sol_next_s   = 1'b0;
          nickel_sol_next_s = 1'b0;
          start_soda_s      = 1'b1;
        end else if (diet_req_r) begin
          state_next_s      = ST_PROD_ON;
          timer_next_s      = PULSE_LOAD;
          soda_sol_next_s   = 1'b0;
          diet_sol_next_s   = 1'b1;
          nickel_sol_next_s = 1'b0;
          start_diet_s      = 1'b1;
        end else if (pending_r != CNT_ZERO) begin
          state_next_s      = ST_NICK_ON;
          timer_next_s      = PULSE_LOAD;
          soda_sol_next_s   = 1'b0;
          diet_sol_next_s   = 1'b0;
          nickel_sol_next_s = 1'b1;
          start_nick_s      = 1'b1;
        end else begin
          state_next_s      = ST_IDLE;
          soda_sol_next_s   = 1'b0;
          diet_sol_next_s   = 1'b0;
          nickel_sol_next_s = 1'b0;
        end
      end

      ST_PROD_ON, ST_NICK_ON: begin
        if (timer_r == TMR_ZERO) begin
          state_next_s      = ST_GAP;
          timer_next_s      = GAP_LOAD;
          soda_sol_next_s   = 1'b0;
          diet_sol_next_s   = 1'b0;
          nickel_sol_next_s = 1'b0;
        end else begin
          timer_next_s      = timer_r - TMR_ONE;
        end
      end

      ST_GAP: begin
        if (timer_r == TMR_ZERO) begin
          state_next_s = ST_IDLE;
        end else begin
          timer_next_s = timer_r - TMR_ONE;
        end
      end

      default: begin
        state_next_s      = ST_IDLE;
        timer_next_s      = TMR_ZERO;
        soda_sol_next_s   = 1'b0;
        diet_sol_next_s   = 1'b0;
        nickel_sol_next_s = 1'b0;
      end
    endcase
  end

  // State, timer, latches, queue and solenoid registers. Reset abandons any
  // pulse in progress; nothing is resumed afterwards.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      timer_r      <= TMR_ZERO;
      soda_req_r   <= 1'b0;
      diet_req_r   <= 1'b0;
      pending_r    <= CNT_ZERO;
      overflow_r   <= 1'b0;
      soda_sol_r   <= 1'b0;
      diet_sol_r   <= 1'b0;
      nickel_sol_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      timer_r      <= timer_next_s;
      soda_req_r   <= soda_req_next_s;
      diet_req_r   <= diet_req_next_s;
      pending_r    <= pending_next_s;
      overflow_r   <= overflow_next_s;
      soda_sol_r   <= soda_sol_next_s;
      diet_sol_r   <= diet_sol_next_s;
      nickel_sol_r <= nickel_sol_next_s;
    end
  end

  assign soda_sol   = soda_sol_r;
  assign diet_sol   = diet_sol_r;
  assign nickel_sol = nickel_sol_r;
  assign pending    = pending_r;
  assign overflow   = overflow_r;
  assign busy       = (state_r != ST_IDLE) | soda_req_r | diet_req_r |
                      (pending_r != CNT_ZERO);

`ifdef VEND_DISP_TALLY_EN
  logic [7:0] tally_r;

  // Product tally, bumped in the cycle a product pulse starts; wraps at 255.
  always_ff @(posedge CLK) begin
    if (rst) begin
      tally_r <= 8'd0;
    end else if (start_soda_s || start_diet_s) begin
      tally_r <= tally_r + 8'd1;
    end else begin
      tally_r <= tally_r;
    end
  end

  assign tally = tally_r;
`endif

endmodule

// File: tb/tb_vend_dispenser.sv
// -----------------------------------------------------------------------------
// tb_vend_dispenser
//
// Directed bench for vend_dispenser. Instance "a" uses default parameters;
// instance "b" uses CNT_W=2 for the counter-overflow scenario. Both share
// clock and reset. Inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point, so "after edge k" below means the value
// produced by rising edge k.
// -----------------------------------------------------------------------------
module tb_vend_dispenser;

  localparam int PW = 4;
  localparam int GW = 2;

  logic       CLK;
  logic       rst;

  logic       give_soda_a, give_diet_a, change_a;
  logic       soda_sol_a, diet_sol_a, nickel_sol_a, busy_a, overflow_a;
  logic [2:0] pending_a;

  logic       give_soda_b, give_diet_b, change_b;
  logic       soda_sol_b, diet_sol_b, nickel_sol_b, busy_b, overflow_b;
  logic [1:0] pending_b;

`ifdef VEND_DISP_TALLY_EN
  logic [7:0] tally_a;
  logic [7:0] tally_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse observer, index 0..2 = soda/diet/nickel of a, 3 = nickel of b
  bit sol_now   [4];
  bit prev_sol  [4];
  bit seen_fall [4];
  int pulses    [4];
  int run_len   [4];
  int low_len   [4];
  int len_err   [4];
  int gap_ne3   [4];
  int onehot_err;

  vend_dispenser #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(3)) dut_a (
    .CLK        (CLK),
    .rst        (rst),
    .giveSoda   (give_soda_a),
    .giveDiet   (give_diet_a),
    .change     (change_a),
    .soda_sol   (soda_sol_a),
    .diet_sol   (diet_sol_a),
    .nickel_sol (nickel_sol_a),
    .busy       (busy_a),
    .pending    (pending_a),
    .overflow   (overflow_a)
`ifdef VEND_DISP_TALLY_EN
    ,
    .tally      (tally_a)
`endif
  );

  vend_dispenser #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(2)) dut_b (
    .CLK        (CLK),
    .rst        (rst),
    .giveSoda   (give_soda_b),
    .giveDiet   (give_diet_b),
    .change     (change_b),
    .soda_sol   (soda_sol_b),
    .diet_sol   (diet_sol_b),
    .nickel_sol (nickel_sol_b),
    .busy       (busy_b),
    .pending    (pending_b),
    .overflow   (overflow_b)
`ifdef VEND_DISP_TALLY_EN
    ,
    .tally      (tally_b)
`endif
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point for the whole bench
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) begin
      prev_sol[i]  = 1'b0;
      seen_fall[i] = 1'b0;
      pulses[i]    = 0;
      run_len[i]   = 0;
      low_len[i]   = 0;
      len_err[i]   = 0;
      gap_ne3[i]   = 0;
    end
    onehot_err = 0;
  endtask

  // Advance one clock and update the pulse observer
  task automatic step();
    @(posedge CLK);
    #1;
    sol_now[0] = soda_sol_a;
    sol_now[1] = diet_sol_a;
    sol_now[2] = nickel_sol_a;
    sol_now[3] = nickel_sol_b;
    if ($countones({soda_sol_a, diet_sol_a, nickel_sol_a}) > 1) onehot_err++;
    if ($countones({soda_sol_b, diet_sol_b, nickel_sol_b}) > 1) onehot_err++;
    for (int i = 0; i < 4; i++) begin
      if (sol_now[i] && !prev_sol[i]) begin
        pulses[i]++;
        if (seen_fall[i] && (low_len[i] != GW + 1)) gap_ne3[i]++;
        run_len[i] = 1;
      end else if (sol_now[i]) begin
        run_len[i]++;
      end else if (prev_sol[i]) begin
        if (run_len[i] != PW) len_err[i]++;
        seen_fall[i] = 1'b1;
        low_len[i]   = 1;
      end else begin
        low_len[i]++;
      end
      prev_sol[i] = sol_now[i];
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

`ifdef VEND_DISP_TALLY_EN
  // One product vend on instance a, spaced 10 cycles
  task automatic vend_a(input bit diet);
    if (diet) give_diet_a = 1'b1; else give_soda_a = 1'b1;
    step();
    give_diet_a = 1'b0;
    give_soda_a = 1'b0;
    steps(9);
  endtask
`endif

  initial begin
    rst = 1'b1;
    give_soda_a = 1'b1; give_diet_a = 1'b0; change_a = 1'b0;
    give_soda_b = 1'b0; give_diet_b = 1'b0; change_b = 1'b0;
    clear_obs();

    // ---------------- Reset with giveSoda held high ----------------
    steps(2);
    check_val("rst_soda",     soda_sol_a,   0);
    check_val("rst_diet",     diet_sol_a,   0);
    check_val("rst_nickel",   nickel_sol_a, 0);
    check_val("rst_pending",  pending_a,    0);
    check_val("rst_overflow", overflow_a,   0);
    check_val("rst_busy",     busy_a,       0);
    rst = 1'b0;
    clear_obs();
    steps(8);
    check_val("rst_hold_pulses", pulses[0], 0);
    check_val("rst_hold_busy",   busy_a,    0);

    // ---------------- Single soda, held 10 cycles ----------------
    give_soda_a = 1'b0;
    step();
    clear_obs();
    give_soda_a = 1'b1;
    step();                                   // edge k
    for (int j = 0; j <= 10; j++) begin
      check_val($sformatf("soda_k+%0d", j), soda_sol_a, (j >= 1 && j <= PW));
      check_val($sformatf("busy_k+%0d", j), busy_a,     (j < PW + GW + 1));
      if (j < 10) step();
    end
    give_soda_a = 1'b0;
    steps(5);
    check_val("single_pulses", pulses[0],  1);
    check_val("single_len",    len_err[0], 0);

    // ---------------- 65 cent flow: soda then 4 nickels ----------------
    clear_obs();
    give_soda_a = 1'b1;
    for (int j = 0; j < 8; j++) begin
      change_a = (j % 2 == 0);
      step();                                 // edge k+j
      check_val($sformatf("flow_pend_k+%0d", j), pending_a, j / 2 + 1);
    end
    change_a = 1'b0;
    steps(40);
    check_val("flow_soda_pulses", pulses[0],  1);
    check_val("flow_soda_len",    len_err[0], 0);
    check_val("flow_nick_pulses", pulses[2],  4);
    check_val("flow_nick_len",    len_err[2], 0);
    check_val("flow_nick_gap",    gap_ne3[2], 0);
    check_val("flow_pending",     pending_a,  0);
    check_val("flow_overflow",    overflow_a, 0);
    check_val("flow_busy",        busy_a,     0);

    // ---------------- Overflow on CNT_W=2 instance ----------------
    clear_obs();
    give_soda_b = 1'b1;
    for (int j = 0; j < 10; j++) begin
      change_b = (j % 2 == 0);
      step();                                 // edge k0+j
      check_val($sformatf("ovf_pend_k0+%0d", j), pending_b,
                (j / 2 + 1 > 3) ? 3 : j / 2 + 1);
      check_val($sformatf("ovf_flag_k0+%0d", j), overflow_b, (j >= 6));
      check_val($sformatf("ovf_soda_k0+%0d", j), soda_sol_b, (j >= 1 && j <= 4));
      check_val($sformatf("ovf_nick_k0+%0d", j), nickel_sol_b, (j >= 8));
    end
    change_b = 1'b0;
    steps(40);
    check_val("ovf_nick_pulses", pulses[3],  4);
    check_val("ovf_nick_len",    len_err[3], 0);
    check_val("ovf_nick_gap",    gap_ne3[3], 0);
    check_val("ovf_pending_end", pending_b,  0);
    check_val("ovf_sticky",      overflow_b, 1);

    // ---------------- Reset in the middle of a soda pulse ----------------
    give_soda_a = 1'b0;
    change_a    = 1'b0;
    step();
    give_soda_a = 1'b1;
    change_a    = 1'b1;
    step();                                   // edge k
    check_val("mid_pend_k", pending_a, 1);
    change_a = 1'b0;
    step();                                   // edge k+1, PROD_ON cycle 1
    check_val("mid_soda_k+1", soda_sol_a, 1);
    change_a = 1'b1;
    step();                                   // edge k+2, PROD_ON cycle 2
    check_val("mid_soda_k+2", soda_sol_a, 1);
    check_val("mid_pend_k+2", pending_a,  2);
    rst = 1'b1;
    step();
    check_val("mid_rst_soda",     soda_sol_a,   0);
    check_val("mid_rst_nickel",   nickel_sol_a, 0);
    check_val("mid_rst_pending",  pending_a,    0);
    check_val("mid_rst_overflow", overflow_b,   0);
    check_val("mid_rst_busy",     busy_a,       0);
    rst      = 1'b0;
    change_a = 1'b0;
    clear_obs();
    steps(30);
    check_val("mid_after_soda", pulses[0], 0);
    check_val("mid_after_nick", pulses[2], 0);
    check_val("mid_after_busy", busy_a,    0);

    // ---------------- Simultaneous soda and diet edges ----------------
    give_soda_a = 1'b0;
    give_diet_a = 1'b0;
    step();
    clear_obs();
    give_soda_a = 1'b1;
    give_diet_a = 1'b1;
    step();                                   // edge k
    for (int j = 0; j <= 14; j++) begin
      check_val($sformatf("both_soda_k+%0d", j), soda_sol_a, (j >= 1 && j <= 4));
      check_val($sformatf("both_diet_k+%0d", j), diet_sol_a, (j >= 8 && j <= 11));
      if (j < 14) step();
    end
    check_val("both_busy_end", busy_a,     0);
    check_val("both_diet_len", len_err[1], 0);
    check_val("onehot",        onehot_err, 0);

`ifdef VEND_DISP_TALLY_EN
    // ---------------- Product tally ----------------
    check_val("tally_after_both", tally_a, 2);
    give_soda_a = 1'b0;
    give_diet_a = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("tally_rst", tally_a, 0);
    step();
    vend_a(1'b0); vend_a(1'b1); vend_a(1'b0); vend_a(1'b1); vend_a(1'b0);
    check_val("tally_5", tally_a, 5);
    for (int v = 0; v < 250; v++) vend_a(1'b0);
    check_val("tally_255", tally_a, 255);
    vend_a(1'b1);
    check_val("tally_wrap", tally_a, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
